// File: rtl/tailptrs_pkg.sv
// Shared types and configuration for the enqueue-side tail pointers.
// Qid/Rid pointer types, queue depths, per-cycle slot limit, free-count widths.
package tailptrs_pkg;
  localparam int IQ_ENTRIES = 8;   // issue queue depth, power of 2
  localparam int RENTRIES   = 8;   // ROB depth, power of 2
  localparam int QSLOTS     = 2;   // max enqueues per cycle (<= 7)

  localparam int QW  = $clog2(IQ_ENTRIES);
  localparam int RW  = $clog2(RENTRIES);
  localparam int QFW = QW + 1;     // free count must reach IQ_ENTRIES
  localparam int RFW = RW + 1;

  typedef logic [QW-1:0] qid_t;
  typedef logic [RW-1:0] rid_t;

  // Requests above the per-cycle slot limit are clipped to it.
  function automatic logic [2:0] clip_req(input logic [2:0] req);
    return (req > 3'(QSLOTS)) ? 3'(QSLOTS) : req;
  endfunction
endpackage

// File: rtl/tailptrs_tail_ring.sv
// tail_ring: one ring of tail pointers plus its free-entry counter.
// Advances by the grant, credits freed entries, and on a mispredict rewinds
// to just after the branch, recomputing occupancy from the head pointer.
module tail_ring #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int FW    = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               grant,
  input  logic [2:0]               freed,
  input  logic                     miss,
  input  logic [PW-1:0]            miss_id,
  input  logic [PW-1:0]            head0,
  output logic [DEPTH-1:0][PW-1:0] ptrs,
  output logic [FW-1:0]            free_cnt
);
  typedef logic [FW:0] fx_t;

  logic [PW-1:0] occ_m1;
  fx_t           free_nxt;

  // Next free count: rollback keeps everything from head through the branch.
  always_comb begin
    occ_m1 = miss_id - head0;  // wraps modulo DEPTH by width
    if (miss)
      free_nxt = fx_t'(DEPTH) - fx_t'(occ_m1) - fx_t'(1) + fx_t'(freed);
    else
      free_nxt = fx_t'(free_cnt) + fx_t'(freed) - fx_t'(grant);
  end

  // Pointer ring and free counter; rollback wins over enqueue.
  always_ff @(posedge clk) begin
    if (rst) free_cnt <= FW'(DEPTH);
    else     free_cnt <= free_nxt[FW-1:0];
    for (int n = 0; n < DEPTH; n++) begin
      if (rst)       ptrs[n] <= PW'(n);
      else if (miss) ptrs[n] <= miss_id + PW'(n + 1);
      else           ptrs[n] <= ptrs[n] + PW'(grant);
    end
  end
endmodule

// File: rtl/tailptrs.sv
// tailptrs: IQ and ROB tail pointer rings with space-limited grants.
// Optional TAILPTR_STATS_EN adds stall counters iq_stall_cnt/rob_stall_cnt.
module tailptrs
  import tailptrs_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 amt,
  input  logic [2:0]                 ramt,
  input  logic [2:0]                 camt,
  input  logic [2:0]                 rcamt,
  input  qid_t                       head0,
  input  rid_t                       rob_head0,
  input  logic                       branchmiss,
  input  qid_t                       miss_qid,
  input  rid_t                       miss_rid,
  output logic [2:0]                 qgrant,
  output logic [2:0]                 rgrant,
  output qid_t [IQ_ENTRIES-1:0]      tails,
  output rid_t [RENTRIES-1:0]        rob_tails,
  output logic [QFW-1:0]             iq_free,
  output logic [RFW-1:0]             rob_free,
  output logic [31:0]                tailcnt
`ifdef TAILPTR_STATS_EN
  ,
  output logic [31:0]                iq_stall_cnt,
  output logic [31:0]                rob_stall_cnt
`endif
);
  logic [2:0] qreq, rreq;

  // Grants: clipped request limited by current free space, zero on mispredict.
  always_comb begin
    qreq   = clip_req(amt);
    rreq   = clip_req(ramt);
    qgrant = 3'd0;
    rgrant = 3'd0;
    if (!branchmiss) begin
      qgrant = (QFW'(qreq) > iq_free)  ? 3'(iq_free)  : qreq;
      rgrant = (RFW'(rreq) > rob_free) ? 3'(rob_free) : rreq;
    end
  end

  tail_ring #(.DEPTH(IQ_ENTRIES)) u_iq (
    .clk      (clk),
    .rst      (rst),
    .grant    (qgrant),
    .freed    (camt),
    .miss     (branchmiss),
    .miss_id  (miss_qid),
    .head0    (head0),
    .ptrs     (tails),
    .free_cnt (iq_free)
  );

  tail_ring #(.DEPTH(RENTRIES)) u_rob (
    .clk      (clk),
    .rst      (rst),
    .grant    (rgrant),
    .freed    (rcamt),
    .miss     (branchmiss),
    .miss_id  (miss_rid),
    .head0    (rob_head0),
    .ptrs     (rob_tails),
    .free_cnt (rob_free)
  );

  // Running total of IQ grants; qgrant is already zero on a mispredict.
  always_ff @(posedge clk) begin
    if (rst) tailcnt <= 32'd0;
    else     tailcnt <= tailcnt + 32'(qgrant);
  end

`ifdef TAILPTR_STATS_EN
  // Count cycles where a request was not fully granted outside rollback.
  always_ff @(posedge clk) begin
    if (rst) begin
      iq_stall_cnt  <= 32'd0;
      rob_stall_cnt <= 32'd0;
    end else if (!branchmiss) begin
      if (qgrant < amt)  iq_stall_cnt  <= iq_stall_cnt + 32'd1;
      if (rgrant < ramt) rob_stall_cnt <= rob_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
